// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, protocol constants, parity helper.
// The PS/2 receiver imports the same package.
package ps2_host_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_RTS,
      ST_SHIFT,
      ST_ACK,
      ST_WAIT_IDLE
   } state_t;

   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RESEND = 8'hFE;

   // Falls after the clock release: 8 data bits, parity, then stop-bit release.
   localparam logic [3:0] FRAME_FALLS = 4'd10;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// Synchroniser and deglitcher for one raw PS/2 line, with a one-cycle strobe on an accepted fall.
// Idle level of an open-collector PS/2 line is high, so everything resets to 1.
module ps2_line_filter #(
   parameter int FILTER = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic fall
);

   localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   // A new level is accepted only after FILTER consecutive samples disagree with the current one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync  <= 2'b11;
         level <= 1'b1;
         cnt   <= '0;
         fall  <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         fall <= 1'b0;
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER - 1)) begin
            level <= sync[1];
            cnt   <= '0;
            fall  <= level;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift one byte with odd parity,
// check the device ACK. Lines are only ever pulled low; the top level builds the open-collector pads.
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int CLKFREQ    = 28000,
   parameter int INHIBIT_US = 120,
   parameter int TIMEOUT_MS = 15,
   parameter int FILTER     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       send,
   output logic       busy,
   output logic       done,
   output logic       error,
   input  logic       ps2clk_in,
   input  logic       ps2dat_in,
   output logic       clk_drive_low,
   output logic       dat_drive_low
);

   localparam int INHIBIT = CLKFREQ * INHIBIT_US / 1000;
   localparam int TOUT    = CLKFREQ * TIMEOUT_MS;
   localparam int IW      = (INHIBIT > 1) ? $clog2(INHIBIT) : 1;
   localparam int TW      = ($clog2(TOUT + 1) > 20) ? $clog2(TOUT + 1) : 20;

   state_t        state, state_nxt;
   logic [7:0]    byte_q, byte_nxt;
   logic [3:0]    n_q, n_nxt;
   logic [TW-1:0] timer_q, timer_nxt;
   logic [IW-1:0] inh_q, inh_nxt;
   logic          ok_q, ok_nxt;
   logic          busy_nxt, done_nxt, error_nxt, clk_low_nxt, dat_low_nxt;
   logic          timeout;

   logic clk_level, clk_fall, dat_level, dat_fall_unused;

   ps2_line_filter #(.FILTER(FILTER)) u_clk_filter (
      .clk   (clk),
      .rst   (rst),
      .raw   (ps2clk_in),
      .level (clk_level),
      .fall  (clk_fall)
   );

   ps2_line_filter #(.FILTER(FILTER)) u_dat_filter (
      .clk   (clk),
      .rst   (rst),
      .raw   (ps2dat_in),
      .level (dat_level),
      .fall  (dat_fall_unused)
   );

   always_comb begin
      state_nxt   = state;
      byte_nxt    = byte_q;
      n_nxt       = n_q;
      timer_nxt   = timer_q;
      inh_nxt     = inh_q;
      ok_nxt      = ok_q;
      busy_nxt    = busy;
      clk_low_nxt = clk_drive_low;
      dat_low_nxt = dat_drive_low;
      done_nxt    = 1'b0;
      error_nxt   = 1'b0;
      timeout     = 1'b0;

      if (state inside {ST_RTS, ST_SHIFT, ST_ACK, ST_WAIT_IDLE}) begin
         timer_nxt = timer_q + 1'b1;
         timeout   = (timer_q == TW'(TOUT - 1));
      end

      // Timeout takes priority over any clock fall seen in the same cycle.
      if (timeout) begin
         state_nxt   = ST_IDLE;
         busy_nxt    = 1'b0;
         clk_low_nxt = 1'b0;
         dat_low_nxt = 1'b0;
         error_nxt   = 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (send) begin
                  byte_nxt    = tx_data;
                  busy_nxt    = 1'b1;
                  clk_low_nxt = 1'b1;
                  inh_nxt     = '0;
                  state_nxt   = ST_INHIBIT;
               end
            end
            ST_INHIBIT: begin
               if (inh_q == IW'(INHIBIT - 1)) begin
                  dat_low_nxt = 1'b1;
                  timer_nxt   = '0;
                  state_nxt   = ST_RTS;
               end else begin
                  inh_nxt = inh_q + 1'b1;
               end
            end
            ST_RTS: begin
               clk_low_nxt = 1'b0;
               n_nxt       = '0;
               state_nxt   = ST_SHIFT;
            end
            ST_SHIFT: begin
               // Data changes just after each device-generated fall; the device samples on the rise.
               if (clk_fall) begin
                  n_nxt = n_q + 1'b1;
                  if (n_q < 4'd8) begin
                     dat_low_nxt = ~byte_q[n_q[2:0]];
                  end else if (n_q == 4'd8) begin
                     dat_low_nxt = ~odd_parity(byte_q);
                  end else begin
                     dat_low_nxt = 1'b0;
                     state_nxt   = ST_ACK;
                  end
               end
            end
            ST_ACK: begin
               if (clk_fall) begin
                  ok_nxt    = ~dat_level;
                  state_nxt = ST_WAIT_IDLE;
               end
            end
            ST_WAIT_IDLE: begin
               if (clk_level && dat_level) begin
                  state_nxt = ST_IDLE;
                  busy_nxt  = 1'b0;
                  done_nxt  = ok_q;
                  error_nxt = ~ok_q;
               end
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         n_q           <= '0;
         timer_q       <= '0;
         inh_q         <= '0;
         ok_q          <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
         clk_drive_low <= 1'b0;
         dat_drive_low <= 1'b0;
      end else begin
         state         <= state_nxt;
         n_q           <= n_nxt;
         timer_q       <= timer_nxt;
         inh_q         <= inh_nxt;
         ok_q          <= ok_nxt;
         busy          <= busy_nxt;
         done          <= done_nxt;
         error         <= error_nxt;
         clk_drive_low <= clk_low_nxt;
         dat_drive_low <= dat_low_nxt;
      end
   end

   always_ff @(posedge clk) begin
      byte_q <= byte_nxt;
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a device-side PS/2 model clocking at 40 us half-period.
module tb_ps2_host_tx;

   localparam int CLKFREQ    = 1000;
   localparam int INHIBIT_US = 120;
   localparam int TIMEOUT_MS = 15;
   localparam int FILTER     = 8;
   localparam int INH        = CLKFREQ * INHIBIT_US / 1000;
   localparam int TOUT       = CLKFREQ * TIMEOUT_MS;
   localparam int HALF       = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       send = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       busy, done, error, clk_drive_low, dat_drive_low;
   logic       bfm_clk = 1'b1;
   logic       bfm_dat = 1'b1;

   wire clk_line = clk_drive_low ? 1'b0 : bfm_clk;
   wire dat_line = dat_drive_low ? 1'b0 : bfm_dat;

   always #5 clk = ~clk;

   ps2_host_tx #(
      .CLKFREQ    (CLKFREQ),
      .INHIBIT_US (INHIBIT_US),
      .TIMEOUT_MS (TIMEOUT_MS),
      .FILTER     (FILTER)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .tx_data       (tx_data),
      .send          (send),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .ps2clk_in     (clk_line),
      .ps2dat_in     (dat_line),
      .clk_drive_low (clk_drive_low),
      .dat_drive_low (dat_drive_low)
   );

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   int inh_cnt = 0;
   logic clk_low_prev = 1'b0;

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (error) err_cnt++;
      if (done && error) both_cnt++;
      if (clk_drive_low && !clk_low_prev) inh_cnt++;
      clk_low_prev = clk_drive_low;
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic check_range(input string tag, input int got, input int lo, input int hi);
      checks++;
      assert (got >= lo && got <= hi) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, got, lo, hi);
      end
   endtask

   task automatic do_send(input logic [7:0] d);
      tx_data = d;
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
   endtask

   task automatic wait_release(output int hold, output time rel_t);
      int t;
      t = 0;
      while (!clk_drive_low && t < 10) begin
         @(negedge clk);
         t++;
      end
      hold = 0;
      while (clk_drive_low && hold < INH + 100) begin
         @(negedge clk);
         hold++;
      end
      rel_t = $time;
   endtask

   task automatic bfm_clocks(input int nclk, input int glitch_at, output logic [10:0] bits);
      bits = '0;
      repeat (20) @(negedge clk);
      bits[0] = dat_line;
      for (int k = 1; k <= nclk; k++) begin
         bfm_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         bfm_clk = 1'b1;
         bits[k] = dat_line;
         if (k == glitch_at) begin
            repeat (10) @(negedge clk);
            bfm_clk = 1'b0;
            repeat (3) @(negedge clk);
            bfm_clk = 1'b1;
            repeat (HALF - 13) @(negedge clk);
         end else begin
            repeat (HALF) @(negedge clk);
         end
      end
   endtask

   task automatic bfm_ack(input logic ack);
      if (ack) bfm_dat = 1'b0;
      repeat (20) @(negedge clk);
      bfm_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      bfm_clk = 1'b1;
      repeat (10) @(negedge clk);
      bfm_dat = 1'b1;
   endtask

   task automatic wait_end(input int limit, output int seen);
      int t;
      t = 0;
      while (!(done || error) && t < limit) begin
         @(negedge clk);
         t++;
      end
      seen = (done || error) ? 1 : 0;
   endtask

   initial begin
      int hold, seen, d0, e0, i0, delta;
      time rel_t;
      logic [10:0] bits;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_clk_low", clk_drive_low, 0);
      check("rst_dat_low", dat_drive_low, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Reset in the middle of a frame, after the 4th fall
      d0 = done_cnt; e0 = err_cnt;
      do_send(8'h55);
      wait_release(hold, rel_t);
      bfm_clocks(4, 0, bits);
      check("mid_busy_before", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_clk_low", clk_drive_low, 0);
      check("mid_rst_dat_low", dat_drive_low, 0);
      check("mid_rst_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (200) @(negedge clk);
      check("mid_rst_no_done", done_cnt - d0, 0);
      check("mid_rst_no_error", err_cnt - e0, 0);
      check("mid_rst_idle", busy, 0);

      // 0xED with ACK, then back-to-back 0xF4
      d0 = done_cnt; e0 = err_cnt;
      do_send(8'hED);
      check("ed_latency", clk_drive_low, 1);
      check("ed_busy", busy, 1);
      wait_release(hold, rel_t);
      check_range("ed_inhibit_hold", hold, INH, INH + 3);
      bfm_clocks(10, 0, bits);
      check("ed_frame", int'(bits), int'({1'b1, 1'b1, 8'hED, 1'b0}));
      bfm_ack(1'b1);
      wait_end(300, seen);
      check("ed_end_seen", seen, 1);
      check("ed_done_now", done, 1);
      check("ed_busy_low", busy, 0);
      i0 = inh_cnt;
      do_send(8'hF4);
      check("b2b_latency", clk_drive_low, 1);
      check("ed_done_one_cycle", done, 0);
      check("ed_done_count", done_cnt - d0, 1);
      check("ed_no_error", err_cnt - e0, 0);

      // 0xF4 frame with a second send while busy
      d0 = done_cnt; e0 = err_cnt;
      repeat (20) @(negedge clk);
      do_send(8'h00);
      wait_release(hold, rel_t);
      check_range("f4_inhibit_hold", hold, INH - 25, INH + 3);
      do_send(8'h00);
      bfm_clocks(10, 0, bits);
      check("f4_frame", int'(bits), int'({1'b1, 1'b0, 8'hF4, 1'b0}));
      bfm_ack(1'b1);
      wait_end(300, seen);
      check("f4_end_seen", seen, 1);
      repeat (300) @(negedge clk);
      check("f4_done_count", done_cnt - d0, 1);
      check("f4_one_frame", inh_cnt - i0, 1);
      check("f4_idle_clk", clk_drive_low, 0);
      check("f4_idle_busy", busy, 0);

      // Device does not ACK
      d0 = done_cnt; e0 = err_cnt;
      do_send(8'h12);
      wait_release(hold, rel_t);
      bfm_clocks(10, 0, bits);
      bfm_ack(1'b0);
      wait_end(300, seen);
      check("nak_end_seen", seen, 1);
      check("nak_error_now", error, 1);
      @(negedge clk);
      check("nak_error_one_cycle", error, 0);
      check("nak_error_count", err_cnt - e0, 1);
      check("nak_no_done", done_cnt - d0, 0);
      check("nak_clk_low", clk_drive_low, 0);
      check("nak_dat_low", dat_drive_low, 0);
      check("nak_busy", busy, 0);

      // Device never clocks: timeout
      repeat (20) @(negedge clk);
      d0 = done_cnt; e0 = err_cnt;
      do_send(8'h34);
      wait_release(hold, rel_t);
      check("tout_dat_held", dat_drive_low, 1);
      wait_end(TOUT + 500, seen);
      check("tout_seen", seen, 1);
      delta = int'(($time - rel_t) / 10);
      check_range("tout_cycles", delta, TOUT - 3, TOUT + 3);
      check("tout_error_now", error, 1);
      check("tout_dat_low", dat_drive_low, 0);
      check("tout_clk_low", clk_drive_low, 0);
      check("tout_busy", busy, 0);
      repeat (5) @(negedge clk);
      check("tout_no_done", done_cnt - d0, 0);
      check("tout_error_count", err_cnt - e0, 1);

      // 3-cycle glitch on the PS/2 clock during shifting
      repeat (20) @(negedge clk);
      d0 = done_cnt; e0 = err_cnt;
      do_send(8'hED);
      wait_release(hold, rel_t);
      bfm_clocks(10, 4, bits);
      check("glitch_frame", int'(bits), int'({1'b1, 1'b1, 8'hED, 1'b0}));
      bfm_ack(1'b1);
      wait_end(300, seen);
      check("glitch_end_seen", seen, 1);
      repeat (5) @(negedge clk);
      check("glitch_done", done_cnt - d0, 1);
      check("glitch_no_error", err_cnt - e0, 0);

      check("never_done_and_error", both_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
